// File: rtl/osc_bank_reader.sv
// Ring-oscillator bank measurement controller: reset, run a fixed window, freeze,
// then read adjacent oscillator pairs and pack the comparisons into a response word.
module osc_bank_reader #(
    parameter int COUNTER_LENGTH = 128,
    parameter int BANK_SIZE      = 16,
    parameter int ADDRESS_SIZE   = 4,
    parameter int RESET_CYCLES   = 4,
    parameter int WINDOW_CYCLES  = 1024,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic                      START,
    output logic                      OSC_RESET,
    output logic                      OSC_EN,
    output logic [ADDRESS_SIZE-1:0]   ADDRESS,
    input  logic [COUNTER_LENGTH-1:0] COUNT,
    output logic                      BUSY,
    output logic                      VALID,
    output logic [BANK_SIZE/2-1:0]    RESPONSE,
    output logic                      TIE
);

    localparam int PAIRS   = BANK_SIZE / 2;
    localparam int MAX_RW  = (WINDOW_CYCLES > RESET_CYCLES) ? WINDOW_CYCLES : RESET_CYCLES;
    localparam int CNT_MAX = (MAX_RW > SETTLE_CYCLES + 1) ? MAX_RW : SETTLE_CYCLES + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]        RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]        RUN_LAST  = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]        SAMPLE_AT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]        HOLD_LAST = CNT_W'(SETTLE_CYCLES);
    localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(BANK_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OSC_RST,
        S_RUN,
        S_READ_A,
        S_READ_B,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ADDRESS_SIZE-1:0]   addr_q, addr_d;
    logic [COUNTER_LENGTH-1:0] a_q, a_d;
    logic [PAIRS-1:0]          acc_q, acc_d;
    logic                      tie_acc_q, tie_acc_d;
    logic [PAIRS-1:0]          response_q, response_d;
    logic                      tie_q, tie_d;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            a_q        <= '0;
            acc_q      <= '0;
            tie_acc_q  <= 1'b0;
            response_q <= '0;
            tie_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            a_q        <= a_d;
            acc_q      <= acc_d;
            tie_acc_q  <= tie_acc_d;
            response_q <= response_d;
            tie_q      <= tie_d;
        end
    end

    // Each read phase holds its address SETTLE_CYCLES+1 cycles; COUNT is sampled
    // after SETTLE_CYCLES stable cycles, the extra cycle is pure hold.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        a_d        = a_q;
        acc_d      = acc_q;
        tie_acc_d  = tie_acc_q;
        response_d = response_q;
        tie_d      = tie_q;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                addr_d = '0;
                if (START) begin
                    state_d   = S_OSC_RST;
                    acc_d     = '0;
                    tie_acc_d = 1'b0;
                end
            end
            S_OSC_RST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (cnt_q == RUN_LAST) begin
                    cnt_d   = '0;
                    addr_d  = '0;
                    state_d = S_READ_A;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READ_A: begin
                if (cnt_q == SAMPLE_AT) begin
                    a_d = COUNT;
                end
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    addr_d  = addr_q + 1'b1;
                    state_d = S_READ_B;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READ_B: begin
                if (cnt_q == SAMPLE_AT) begin
                    for (int k = 0; k < PAIRS; k++) begin
                        if (addr_q == ADDRESS_SIZE'(2 * k + 1)) begin
                            acc_d[k] = (a_q > COUNT);
                        end
                    end
                    if (a_q == COUNT) begin
                        tie_acc_d = 1'b1;
                    end
                end
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (addr_q == LAST_ADDR) begin
                        // Publish on entry to DONE so RESPONSE is new while VALID is high.
                        addr_d     = '0;
                        response_d = acc_q;
                        tie_d      = tie_acc_q;
                        state_d    = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_READ_A;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                addr_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign OSC_RESET = (state_q == S_OSC_RST);
    assign OSC_EN    = (state_q == S_RUN);
    assign BUSY      = (state_q == S_OSC_RST) || (state_q == S_RUN) ||
                       (state_q == S_READ_A)  || (state_q == S_READ_B);
    assign VALID     = (state_q == S_DONE);
    assign ADDRESS   = addr_q;
    assign RESPONSE  = response_q;
    assign TIE       = tie_q;

endmodule

// File: tb/tb_osc_bank_reader.sv
// Directed self-checking bench for osc_bank_reader with a small behavioural
// oscillator bank whose COUNT can lag behind ADDRESS changes.
module tb_osc_bank_reader;

    localparam int CL = 128;
    localparam int BS = 8;
    localparam int AS = 3;

    logic          CLOCK;
    logic          RESET;
    logic          START;
    logic          OSC_RESET;
    logic          OSC_EN;
    logic [AS-1:0] ADDRESS;
    logic [CL-1:0] COUNT;
    logic          BUSY;
    logic          VALID;
    logic [3:0]    RESPONSE;
    logic          TIE;

    int tests_run    = 0;
    int tests_failed = 0;

    osc_bank_reader #(
        .COUNTER_LENGTH(CL),
        .BANK_SIZE(BS),
        .ADDRESS_SIZE(AS),
        .RESET_CYCLES(4),
        .WINDOW_CYCLES(16),
        .SETTLE_CYCLES(2)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .START(START),
        .OSC_RESET(OSC_RESET),
        .OSC_EN(OSC_EN),
        .ADDRESS(ADDRESS),
        .COUNT(COUNT),
        .BUSY(BUSY),
        .VALID(VALID),
        .RESPONSE(RESPONSE),
        .TIE(TIE)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Bank model: after an ADDRESS change, COUNT shows either junk or the previous
    // value for 'lag' cycles before switching to the selected oscillator's count.
    logic [CL-1:0] vals [BS];
    logic [CL-1:0] shown = '0;
    logic [AS-1:0] last_addr = '0;
    int            age = 100;
    int            lag = 0;
    bit            junk_mode = 1'b0;
    localparam logic [CL-1:0] JUNK = 128'd1000;

    always @(posedge CLOCK) begin
        #1;
        if (ADDRESS != last_addr) begin
            last_addr = ADDRESS;
            age = 0;
        end else if (age < 100) begin
            age = age + 1;
        end
        if (age >= lag)
            shown = vals[ADDRESS];
        else if (junk_mode)
            shown = JUNK;
    end
    assign COUNT = shown;

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic load_basic;
        vals[0] = 128'd100; vals[1] = 128'd50;
        vals[2] = 128'd20;  vals[3] = 128'd80;
        vals[4] = 128'd7;   vals[5] = 128'd7;
        vals[6] = 128'd300; vals[7] = 128'd299;
    endtask

    // Pulses START for one edge and returns the index of the cycle where VALID
    // is seen (the accepting edge is edge 1); 0 if it never appears.
    task automatic start_and_wait(output int n);
        n = 0;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (VALID) begin
                n = i;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        START = 1'b0;
        tick();
        tick();
        tests_run++; if (OSC_RESET !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_osc_reset got %b want 0", OSC_RESET); end
        tests_run++; if (OSC_EN !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_osc_en got %b want 0", OSC_EN); end
        tests_run++; if (ADDRESS !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_address got %0d want 0", ADDRESS); end
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", BUSY); end
        tests_run++; if (VALID !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %b want 0", VALID); end
        tests_run++; if (RESPONSE !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_response got %b want 0000", RESPONSE); end
        tests_run++; if (TIE !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tie got %b want 0", TIE); end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_timeline;
        logic [6:0] got;
        logic [6:0] exp;
        logic [2:0] exp_addr;
        load_basic();
        lag = 0;
        junk_mode = 1'b0;
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int n = 1; n <= 46; n++) begin
            exp_addr = (n >= 21 && n <= 44) ? 3'((n - 21) / 3) : 3'd0;
            exp = {(n <= 4), (n >= 5 && n <= 20), (n <= 44), (n == 45), exp_addr};
            got = {OSC_RESET, OSC_EN, BUSY, VALID, ADDRESS};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("[TB] FAIL timeline cycle %0d {rst,en,busy,valid,addr} got %b want %b", n, got, exp);
            end
            if (n == 44) begin
                tests_run++; if (RESPONSE !== 4'd0) begin tests_failed++; $display("[TB] FAIL partial_hidden got %b want 0000", RESPONSE); end
            end
            if (n == 45) begin
                tests_run++; if (RESPONSE !== 4'b1001) begin tests_failed++; $display("[TB] FAIL basic_response got %b want 1001", RESPONSE); end
                tests_run++; if (TIE !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_tie got %b want 1", TIE); end
            end
            tick();
        end
    endtask

    task automatic test_settle;
        int n;
        load_basic();
        lag = 1;
        junk_mode = 1'b1;
        tick();
        start_and_wait(n);
        tests_run++; if (n !== 45) begin tests_failed++; $display("[TB] FAIL settle_ok_latency got %0d want 45", n); end
        tests_run++; if (RESPONSE !== 4'b1001) begin tests_failed++; $display("[TB] FAIL settle_ok_response got %b want 1001", RESPONSE); end
        tick();
        lag = 2;
        junk_mode = 1'b0;
        tick();
        start_and_wait(n);
        tests_run++; if (n !== 45) begin tests_failed++; $display("[TB] FAIL settle_late_latency got %0d want 45", n); end
        tests_run++; if (RESPONSE !== 4'b0110) begin tests_failed++; $display("[TB] FAIL settle_late_response got %b want 0110", RESPONSE); end
        tests_run++; if (TIE !== 1'b1) begin tests_failed++; $display("[TB] FAIL settle_late_tie got %b want 1", TIE); end
        tick();
        lag = 0;
    endtask

    task automatic test_ignore_start;
        int valid_count;
        int valid_at;
        int n;
        load_basic();
        tick();
        valid_count = 0;
        valid_at = 0;
        START = 1'b1;
        tick();
        for (int i = 1; i <= 60; i++) begin
            START = (i == 5 || i == 30);
            if (VALID) begin
                valid_count++;
                valid_at = i;
            end
            tick();
        end
        START = 1'b0;
        tests_run++; if (valid_count !== 1) begin tests_failed++; $display("[TB] FAIL ignore_valid_count got %0d want 1", valid_count); end
        tests_run++; if (valid_at !== 45) begin tests_failed++; $display("[TB] FAIL ignore_valid_cycle got %0d want 45", valid_at); end

        vals[0] = 128'd1; vals[1] = 128'd2;
        vals[2] = 128'd9; vals[3] = 128'd3;
        vals[4] = 128'd9; vals[5] = 128'd8;
        vals[6] = 128'd0; vals[7] = 128'd5;
        n = 0;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 30) begin
                tests_run++; if ({RESPONSE, TIE} !== 5'b10011) begin tests_failed++; $display("[TB] FAIL hold_old_result got %b want 10011", {RESPONSE, TIE}); end
            end
            if (VALID) begin
                n = i;
                break;
            end
            tick();
        end
        tests_run++; if (n !== 45) begin tests_failed++; $display("[TB] FAIL second_latency got %0d want 45", n); end
        tests_run++; if ({RESPONSE, TIE} !== 5'b01100) begin tests_failed++; $display("[TB] FAIL second_result got %b want 01100", {RESPONSE, TIE}); end
        tick();
    endtask

    task automatic test_reset_mid;
        int valid_count;
        int n;
        load_basic();
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        RESET = 1'b1;
        tick();
        tests_run++; if (OSC_EN !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_osc_en got %b want 0", OSC_EN); end
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_busy got %b want 0", BUSY); end
        tests_run++; if (RESPONSE !== 4'd0) begin tests_failed++; $display("[TB] FAIL midreset_response got %b want 0000", RESPONSE); end
        tests_run++; if (TIE !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_tie got %b want 0", TIE); end
        RESET = 1'b0;
        valid_count = 0;
        for (int i = 0; i < 50; i++) begin
            if (VALID) valid_count++;
            tick();
        end
        tests_run++; if (valid_count !== 0) begin tests_failed++; $display("[TB] FAIL midreset_no_valid got %0d want 0", valid_count); end
        start_and_wait(n);
        tests_run++; if (n !== 45) begin tests_failed++; $display("[TB] FAIL after_reset_latency got %0d want 45", n); end
        tests_run++; if ({RESPONSE, TIE} !== 5'b10011) begin tests_failed++; $display("[TB] FAIL after_reset_result got %b want 10011", {RESPONSE, TIE}); end
        tick();
    endtask

    task automatic test_wide;
        int n;
        logic [CL-1:0] top;
        top = 128'd1 << 127;
        vals[0] = top;           vals[1] = top - 128'd1;
        vals[2] = 128'd0;        vals[3] = 128'd1;
        vals[4] = 128'd5;        vals[5] = 128'd3;
        vals[6] = 128'd1 << 126; vals[7] = top;
        tick();
        start_and_wait(n);
        tests_run++; if (n !== 45) begin tests_failed++; $display("[TB] FAIL wide_latency got %0d want 45", n); end
        tests_run++; if (RESPONSE !== 4'b0101) begin tests_failed++; $display("[TB] FAIL wide_response got %b want 0101", RESPONSE); end
        tests_run++; if (TIE !== 1'b0) begin tests_failed++; $display("[TB] FAIL wide_tie got %b want 0", TIE); end
        tick();
    endtask

    initial begin
        RESET = 1'b1;
        START = 1'b0;
        load_basic();
        test_reset();
        test_timeline();
        test_settle();
        test_ignore_start();
        test_reset_mid();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
